// File: rtl/alu_iter_exec.sv
// Execute-stage ALU. Single-cycle decode of the 4-bit ALU control code.
// MULT uses an iterative signed shift-add multiplier that stalls the pipeline until the product is ready.
module alu_iter_exec #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             stall_o,
  output logic             done_o
);

  localparam int unsigned CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX, S_DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               sign;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   prod_lo;
  logic [WIDTH-1:0]   hi_q;

  logic               accept;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;

  assign accept = (state == S_IDLE) & valid_i & (ctrl_i == 4'd11) & ~flush_i;
  assign stall_o = accept | (state == S_MUL) | (state == S_FIX);
  assign done_o = (state == S_DONE);
  assign hi_o = hi_q;

  // Magnitudes are unsigned, so the most negative input maps to 2^(WIDTH-1) exactly.
  assign a_abs = src1_i[WIDTH-1] ? (~src1_i + 1'b1) : src1_i;
  assign b_abs = src2_i[WIDTH-1] ? (~src2_i + 1'b1) : src2_i;

  // The carry out of the upper-half add is shifted back into the accumulator.
  assign psum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
  assign prod_fix = sign ? (~acc + 1'b1) : acc;

  assign sum = src1_i + src2_i;
  assign diff = src1_i - src2_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      sign    <= 1'b0;
      cnt     <= '0;
      prod_lo <= '0;
      hi_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mcand  <= a_abs;
            mplier <= b_abs;
            sign   <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
            acc    <= '0;
            cnt    <= '0;
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (flush_i) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            sign    <= 1'b0;
            cnt     <= '0;
            prod_lo <= '0;
            state   <= S_IDLE;
          end else begin
            acc    <= {psum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(MUL_CYCLES - 1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush_i) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            sign    <= 1'b0;
            cnt     <= '0;
            prod_lo <= '0;
            state   <= S_IDLE;
          end else begin
            prod_lo <= prod_fix[WIDTH-1:0];
            hi_q    <= prod_fix[2*WIDTH-1:WIDTH];
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    result_o   = '0;
    zero_o     = 1'b0;
    overflow_o = 1'b0;
    case (state)
      S_IDLE: begin
        case (ctrl_i)
          4'd0: begin
            result_o = src1_i & src2_i;
            zero_o   = (result_o == '0);
          end
          4'd1, 4'd9: begin
            result_o = src1_i | src2_i;
            zero_o   = (result_o == '0);
          end
          4'd2: begin
            result_o   = sum;
            zero_o     = (sum == '0);
            overflow_o = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) & (sum[WIDTH-1] != src1_i[WIDTH-1]);
          end
          4'd3: begin
            result_o   = diff;
            zero_o     = (diff == '0);
            overflow_o = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) & (diff[WIDTH-1] != src1_i[WIDTH-1]);
          end
          4'd4: begin
            result_o = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            zero_o   = (result_o == '0);
          end
          4'd7: begin
            result_o = diff;
            zero_o   = (src1_i == src2_i);
          end
          4'd8: begin
            result_o = {src2_i[15:0], {(WIDTH-16){1'b0}}};
            zero_o   = (result_o == '0);
          end
          4'd10: begin
            result_o = diff;
            zero_o   = (src1_i != src2_i);
          end
          default: begin
            result_o = '0;
            zero_o   = 1'b0;
          end
        endcase
      end
      S_DONE: begin
        result_o = prod_lo;
        zero_o   = (prod_lo == '0);
      end
      default: begin
        result_o   = '0;
        zero_o     = 1'b0;
        overflow_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed testbench for alu_iter_exec: combinational ops, signed multiply latency,
// reset and flush aborts, back-to-back multiplies.
module tb_alu_iter_exec;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        overflow;
  logic        stall;
  logic        done;

  int unsigned tests = 0;
  int unsigned fails = 0;

  alu_iter_exec #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .ctrl_i     (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .flush_i    (flush),
    .result_o   (result),
    .hi_o       (hi),
    .zero_o     (zero),
    .overflow_o (overflow),
    .stall_o    (stall),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic comb_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_ovf);
    valid = 1'b1;
    ctrl  = c;
    src1  = a;
    src2  = b;
    #1;
    chk({tag, "_res"}, 64'(result), 64'(exp_res));
    chk({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    step();
  endtask

  // Presents a MULT in cycle 0 and checks through the DONE cycle (34); returns sitting in DONE.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    valid = 1'b1;
    ctrl  = 4'd11;
    src1  = a;
    src2  = b;
    flush = 1'b0;
    #1;
    chk({tag, "_stall_c0"}, 64'(stall), 64'd1);
    for (int i = 1; i <= 33; i++) begin
      step();
      if (i == 5) begin
        src1 = 32'hDEAD_BEEF;
        src2 = 32'h1357_9BDF;
      end
      if (stall !== 1'b1 || done !== 1'b0 || result !== 32'd0) begin
        chk($sformatf("%s_busy_c%0d", tag, i), {31'd0, stall, 31'd0, done}, 64'h1_0000_0000);
      end
    end
    tests++;
    step();
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    chk({tag, "_lo"}, 64'(result), 64'(exp_lo));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_zero_done"}, 64'(zero), 64'(exp_lo == 32'd0));
    valid = 1'b0;
    ctrl  = 4'd0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    ctrl  = 4'd0;
    src1  = '0;
    src2  = '0;
    flush = 1'b0;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    comb_op("add",      4'd2,  32'd7,          32'hFFFF_FFFD, 32'd4,          1'b0, 1'b0);
    comb_op("add_ovf",  4'd2,  32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  1'b0, 1'b1);
    comb_op("sub_ovf",  4'd3,  32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  1'b0, 1'b1);
    comb_op("beq",      4'd7,  32'h55,         32'h55,        32'd0,          1'b1, 1'b0);
    comb_op("bne",      4'd10, 32'h55,         32'h55,        32'd0,          1'b0, 1'b0);
    comb_op("bne_ne",   4'd10, 32'h56,         32'h55,        32'd1,          1'b1, 1'b0);
    comb_op("lui",      4'd8,  32'hFFFF_FFFF,  32'h1234,      32'h1234_0000,  1'b0, 1'b0);
    comb_op("and_zero", 4'd0,  32'hF0,         32'h0F,        32'd0,          1'b1, 1'b0);
    comb_op("or",       4'd1,  32'hF0,         32'h0F,        32'hFF,         1'b0, 1'b0);
    comb_op("ori",      4'd9,  32'h1200_0000,  32'h34,        32'h1200_0034,  1'b0, 1'b0);
    comb_op("slt",      4'd4,  32'hFFFF_FFFF,  32'd1,         32'd1,          1'b0, 1'b0);
    comb_op("slt_no",   4'd4,  32'd1,          32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0);
    comb_op("unused5",  4'd5,  32'd7,          32'd9,         32'd0,          1'b0, 1'b0);
    comb_op("unused14", 4'd14, 32'd0,          32'd0,         32'd0,          1'b0, 1'b0);
    valid = 1'b0;

    run_mult("m_neg", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
    step();
    chk("m_neg_idle_done", 64'(done), 64'd0);

    // Reset mid-multiply: accept at edge 0, assert reset in cycle 10.
    valid = 1'b1;
    ctrl  = 4'd11;
    src1  = 32'd9;
    src2  = 32'd9;
    for (int i = 0; i < 10; i++) step();
    valid = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst_abort_stall", 64'(stall), 64'd0);
    chk("rst_abort_done", 64'(done), 64'd0);
    chk("rst_abort_hi", 64'(hi), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0) chk($sformatf("rst_abort_nodone_%0d", i), 64'(done), 64'd0);
    end
    tests++;

    run_mult("m_min", 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h4000_0000);
    step();

    // Flush mid-multiply: accept at edge 0, flush during cycle 20.
    valid = 1'b1;
    ctrl  = 4'd11;
    src1  = 32'd7;
    src2  = 32'd7;
    for (int i = 0; i < 20; i++) step();
    flush = 1'b1;
    #1;
    chk("flush_stall_mul", 64'(stall), 64'd1);
    step();
    flush = 1'b0;
    valid = 1'b0;
    ctrl  = 4'd0;
    #1;
    chk("flush_stall_idle", 64'(stall), 64'd0);
    chk("flush_hi_kept", 64'(hi), 64'h4000_0000);
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0) chk($sformatf("flush_nodone_%0d", i), 64'(done), 64'd0);
    end
    tests++;
    chk("flush_hi_final", 64'(hi), 64'h4000_0000);

    // Back-to-back: second MULT presented in the IDLE cycle after DONE (cycle 35).
    run_mult("b2b_1", 32'd2, 32'd3, 32'd6, 32'd0);
    step();
    run_mult("b2b_2", 32'd4, 32'd5, 32'd20, 32'd0);
    step();
    chk("b2b_end_done", 64'(done), 64'd0);
    chk("b2b_end_hi", 64'(hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU that directly consumes the 4-bit ALU control code from the ALU controller.
- All non-multiply operations are single-cycle combinational.
- MULT (code 11) runs on an iterative signed 32x32 shift-add multiplier. The block raises a stall to freeze the pipeline until the product is ready.
- It sits between the ID/EX pipeline register and the EX/MEM register.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_CYCLES, 32, shift-add iterations; must equal WIDTH.

Ports:
- clk_i  in  1  system clock; rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  EX stage holds a real instruction.
- ctrl_i  in  4  ALU control code from the ALU controller.
- src1_i  in  WIDTH  operand A (rs).
- src2_i  in  WIDTH  operand B (rt or extended immediate).
- flush_i  in  1  synchronous abort of an in-flight multiply.
- result_o  out  WIDTH  ALU result; low word of the product on MULT.
- hi_o  out  WIDTH  high word of the last completed product.
- zero_o  out  1  branch condition.
- overflow_o  out  1  signed overflow for ADD/SUB.
- stall_o  out  1  hold PC, IF/ID and ID/EX.
- done_o  out  1  one-cycle pulse when the product is valid.

Behaviour:
- Ctrl code decode (combinational, valid only in IDLE):
  - 0: AND.
  - 1: OR.
  - 2: ADD.
  - 3: SUB.
  - 4: SLT, signed; result 1 or 0.
  - 7: BEQ. result = A−B; zero_o = (A==B).
  - 8: LUI. result = {B[15:0], 16'h0}.
  - 9: ORI. A | B.
  - 10: BNE. result = A−B; zero_o = (A!=B).
  - 11: MULT.
  - 5, 6, 12–15: result 0, zero_o 0, overflow_o 0.
- zero_o for codes other than 7/10 = (result_o == 0).
- overflow_o = signed overflow for codes 2 and 3 only; 0 otherwise. Wrap-around arithmetic; no trap.
- FSM states: IDLE, MUL, FIX, DONE.
  - IDLE → MUL when valid_i & ctrl_i==11 & !flush_i. On that edge latch |A|, |B| and sign = A[31]^B[31]; clear the 64-bit accumulator; iteration counter = 0.
  - MUL: each cycle, if multiplier LSB is 1, add the multiplicand into the upper accumulator half; then shift right by 1 (carry kept); counter++. After MUL_CYCLES iterations → FIX.
  - FIX: if sign, two's-complement negate the 64-bit product; latch into prod_hi/prod_lo; → DONE.
  - DONE: done_o = 1; result_o = prod_lo; hi_o updated. → IDLE unconditionally.
- Latency: acceptance edge = cycle 0; MUL occupies cycles 1–32, FIX cycle 33, DONE cycle 34.
- stall_o = (state ∈ {MUL, FIX}) | (state==IDLE & valid_i & ctrl_i==11 & !flush_i).
  - stall_o is 0 in DONE, so the pipeline advances on the DONE edge.
  - The same MULT is not re-accepted because DONE always returns to IDLE.
- Back-to-back MULT: the next instruction is accepted in the IDLE cycle after DONE (1 bubble-free IDLE sample).
- result_o in MUL/FIX = 0. zero_o/overflow_o = 0 outside IDLE, except zero_o = (prod_lo==0) in DONE.
- hi_o holds its value until the next DONE; all other registered state is cleared on abort.
- flush_i in MUL/FIX → IDLE next edge, no done_o, hi_o unchanged.
- rst_i asserted at any time: immediately state = IDLE, accumulator/counter/prod = 0, hi_o = 0, done_o = 0, stall_o follows the IDLE equation. A multiply in flight is discarded.
- Operand changes on src1_i/src2_i during MUL are ignored; operands are latched at acceptance.
- Corner case: A = 0x80000000; |A| is handled as an unsigned 32-bit value, so the product is exact for all signed inputs.

Test Plan:
- ADD: ctrl=2, A=7, B=0xFFFFFFFD → result 4, overflow 0, zero 0, stall 0 same cycle.
- SUB overflow: ctrl=3, A=0x80000000, B=1 → result 0x7FFFFFFF, overflow 1.
- BEQ/BNE: ctrl=7, A=B=0x55 → zero 1; ctrl=10, same operands → zero 0. LUI: ctrl=8, B=0x1234 → 0x12340000.
- MULT signed: ctrl=11, A=−3, B=5 → stall 1 for cycles 0–33; done_o in cycle 34 with result 0xFFFFFFF1, hi 0xFFFFFFFF. A=0x80000000, B=0x80000000 → hi 0x40000000, lo 0.
- Abort: rst_i high at cycle 10 of MULT → stall drops (valid_i low), no done_o, hi_o=0. Repeat with flush_i at cycle 20 → IDLE, hi_o keeps the prior value.
- Back-to-back: two MULTs (2×3, then 4×5) → done at cycle 34 with 6, second accepted cycle 35, done at cycle 69 with 20.
